// File: rtl/iob_fifo_sync_asym_ctrl.sv
// Synchronous FIFO controller for an asymmetric-width two-port RAM.
// Owns the write/read pointers and the occupancy counter; the RAM only stores data.
module iob_fifo_sync_asym_ctrl #(
    parameter int unsigned W_DATA_W = 32,
    parameter int unsigned R_DATA_W = 8,
    parameter int unsigned ADDR_W   = 4,
    localparam int unsigned MAXDATA_W  = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
    localparam int unsigned MINDATA_W  = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W,
    localparam int unsigned RATIO_LOG2 = $clog2(MAXDATA_W / MINDATA_W),
    localparam int unsigned W_ADDR_W   = (W_DATA_W > R_DATA_W) ? ADDR_W - RATIO_LOG2 : ADDR_W,
    localparam int unsigned R_ADDR_W   = (R_DATA_W > W_DATA_W) ? ADDR_W - RATIO_LOG2 : ADDR_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                w_en_i,
    input  logic [W_DATA_W-1:0] w_data_i,
    output logic                w_full_o,
    input  logic                r_en_i,
    output logic [R_DATA_W-1:0] r_data_o,
    output logic                r_empty_o,
    output logic [ADDR_W:0]     level_o,
    output logic                ext_mem_w_en_o,
    output logic [W_ADDR_W-1:0] ext_mem_w_addr_o,
    output logic [W_DATA_W-1:0] ext_mem_w_data_o,
    output logic                ext_mem_r_en_o,
    output logic [R_ADDR_W-1:0] ext_mem_r_addr_o,
    input  logic [R_DATA_W-1:0] ext_mem_r_data_i
);

    localparam int unsigned LVL_W  = ADDR_W + 1;
    localparam int unsigned W_INCR = W_DATA_W / MINDATA_W;
    localparam int unsigned R_INCR = R_DATA_W / MINDATA_W;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    localparam logic [LVL_W-1:0] FULL_THR  = LVL_W'(DEPTH - W_INCR);
    localparam logic [LVL_W-1:0] EMPTY_THR = LVL_W'(R_INCR);

    logic [W_ADDR_W-1:0] w_ptr, w_ptr_nxt;
    logic [R_ADDR_W-1:0] r_ptr, r_ptr_nxt;
    logic [LVL_W-1:0]    level, level_nxt;
    logic [LVL_W-1:0]    w_inc, r_dec;
    logic                w_acc, r_acc;

    // Flags depend only on the registered level, never on the requests.
    assign w_full_o  = level > FULL_THR;
    assign r_empty_o = level < EMPTY_THR;
    assign level_o   = level;

    assign w_acc = w_en_i & ~w_full_o;
    assign r_acc = r_en_i & ~r_empty_o;

    assign ext_mem_w_en_o   = w_acc;
    assign ext_mem_w_addr_o = w_ptr;
    assign ext_mem_w_data_o = w_data_i;
    assign ext_mem_r_en_o   = r_acc;
    assign ext_mem_r_addr_o = r_ptr;
    assign r_data_o         = ext_mem_r_data_i;

    // Next pointers and net occupancy change; flags guarantee no wrap of level.
    always_comb begin
        w_ptr_nxt = w_ptr;
        r_ptr_nxt = r_ptr;
        w_inc     = '0;
        r_dec     = '0;
        if (w_acc) begin
            w_ptr_nxt = w_ptr + W_ADDR_W'(1);
            w_inc     = LVL_W'(W_INCR);
        end
        if (r_acc) begin
            r_ptr_nxt = r_ptr + R_ADDR_W'(1);
            r_dec     = LVL_W'(R_INCR);
        end
        level_nxt = level + w_inc - r_dec;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_ptr <= '0;
            r_ptr <= '0;
            level <= '0;
        end else begin
            w_ptr <= w_ptr_nxt;
            r_ptr <= r_ptr_nxt;
            level <= level_nxt;
        end
    end

endmodule
